// File: rtl/loop_chk_pkg.sv
// Shared types and constants for the counting-loop invariant monitor.
package loop_chk_pkg;

  localparam int W_DEF  = 10;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    FAIL = 2'd3
  } state_e;

  typedef logic [2:0] err_code_t;

  localparam err_code_t ERR_NONE = 3'd0;
  localparam err_code_t ERR_INIT = 3'd1;
  localparam err_code_t ERR_STEP = 3'd2;
  localparam err_code_t ERR_INV  = 3'd3;
  localparam err_code_t ERR_POST = 3'd4;

endpackage

// File: rtl/loop_step_checker.sv
// Combinational per-sample checks: step rule against the previous sample and
// the loop invariant sn == i-1, all modulo 2^W.
module loop_step_checker
  import loop_chk_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] prev_i,
  input  logic [W-1:0] prev_sn,
  input  logic         prev_sel,
  input  logic [W-1:0] i,
  input  logic [W-1:0] sn,
  output logic         step_ok,
  output logic         inv_ok
);

  logic [W-1:0] i_inc;
  logic [W-1:0] sn_inc;
  logic [W-1:0] i_dec;

  // W-bit sums wrap naturally, so 2^W-1 -> 0 counts as a legal step.
  assign i_inc  = prev_i + W'(1);
  assign sn_inc = prev_sn + W'(1);
  assign i_dec  = i - W'(1);

  always_comb begin
    step_ok = 1'b0;
    if (prev_sel) step_ok = (i == i_inc) && (sn == sn_inc);
    else          step_ok = (i == prev_i) && (sn == prev_sn);
  end

  assign inv_ok = (sn == i_dec);

endmodule

// File: rtl/loop_invariant_monitor.sv
// Checker for the counting-loop datapath: init, step, invariant and exit
// post-condition, with a sticky first-error code and sample counters.
module loop_invariant_monitor
  import loop_chk_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          selector,
  input  logic [W-1:0]  i,
  input  logic [W-1:0]  sn,
  input  logic [W-1:0]  n,
  input  logic          done,
  output logic          err,
  output logic [2:0]    err_code,
  output logic          pass,
  output logic [CW-1:0] check_count,
  output logic [CW-1:0] fail_cycle,
  output logic          busy
);

  state_e        state_q, state_d;
  logic [W-1:0]  prev_i_q, prev_i_d;
  logic [W-1:0]  prev_sn_q, prev_sn_d;
  logic          prev_sel_q, prev_sel_d;
  logic          err_q, err_d;
  err_code_t     code_q, code_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fail_q, fail_d;

  logic          step_ok;
  logic          inv_ok;
  logic [CW-1:0] cnt_inc;
  logic [W-1:0]  post_sn;
  logic          post_ok;

  loop_step_checker #(.W(W)) u_step (
    .prev_i   (prev_i_q),
    .prev_sn  (prev_sn_q),
    .prev_sel (prev_sel_q),
    .i        (i),
    .sn       (sn),
    .step_ok  (step_ok),
    .inv_ok   (inv_ok)
  );

  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
  // A same-cycle sample supersedes the held one for the exit check.
  assign post_sn = in_valid ? sn : prev_sn_q;
  assign post_ok = (post_sn == n) || (post_sn == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      prev_i_q   <= '0;
      prev_sn_q  <= '0;
      prev_sel_q <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
      pass_q     <= 1'b0;
      cnt_q      <= '0;
      fail_q     <= '0;
    end else begin
      state_q    <= state_d;
      prev_i_q   <= prev_i_d;
      prev_sn_q  <= prev_sn_d;
      prev_sel_q <= prev_sel_d;
      err_q      <= err_d;
      code_q     <= code_d;
      pass_q     <= pass_d;
      cnt_q      <= cnt_d;
      fail_q     <= fail_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    prev_i_d   = prev_i_q;
    prev_sn_d  = prev_sn_q;
    prev_sel_d = prev_sel_q;
    err_d      = err_q;
    code_d     = code_q;
    pass_d     = pass_q;
    cnt_d      = cnt_q;
    fail_d     = fail_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = cnt_inc;
          if ((i == W'(1)) && (sn == '0)) begin
            state_d    = RUN;
            prev_i_d   = i;
            prev_sn_d  = sn;
            prev_sel_d = selector;
          end else begin
            state_d = FAIL;
            err_d   = 1'b1;
            code_d  = ERR_INIT;
            fail_d  = cnt_inc;
          end
        end
      end
      RUN: begin
        if (in_valid) begin
          cnt_d      = cnt_inc;
          prev_i_d   = i;
          prev_sn_d  = sn;
          prev_sel_d = selector;
        end
        // Priority: step over invariant over post-condition.
        if (in_valid && !step_ok) begin
          state_d = FAIL;
          err_d   = 1'b1;
          code_d  = ERR_STEP;
          fail_d  = cnt_inc;
        end else if (in_valid && !inv_ok) begin
          state_d = FAIL;
          err_d   = 1'b1;
          code_d  = ERR_INV;
          fail_d  = cnt_inc;
        end else if (done) begin
          if (post_ok) begin
            state_d = DONE;
            pass_d  = 1'b1;
          end else begin
            state_d = FAIL;
            err_d   = 1'b1;
            code_d  = ERR_POST;
            fail_d  = in_valid ? cnt_inc : cnt_q;
          end
        end
      end
      DONE, FAIL: begin
        state_d = state_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    err         = err_q;
    err_code    = code_q;
    pass        = pass_q;
    check_count = cnt_q;
    fail_cycle  = fail_q;
  end

endmodule

// File: tb/tb_loop_invariant_monitor.sv
// Directed bench for loop_invariant_monitor; a second instance with a 4-bit
// sample counter shares the stimulus to exercise counter saturation.
module tb_loop_invariant_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        selector = 1'b0;
  logic [9:0]  i = '0;
  logic [9:0]  sn = '0;
  logic [9:0]  n = '0;
  logic        done = 1'b0;

  logic        err, err4;
  logic [2:0]  err_code, err_code4;
  logic        pass, pass4;
  logic [15:0] check_count, fail_cycle;
  logic [3:0]  check_count4, fail_cycle4;
  logic        busy, busy4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  loop_invariant_monitor #(.W(10), .CW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .selector(selector),
    .i(i), .sn(sn), .n(n), .done(done),
    .err(err), .err_code(err_code), .pass(pass),
    .check_count(check_count), .fail_cycle(fail_cycle), .busy(busy)
  );

  loop_invariant_monitor #(.W(10), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .selector(selector),
    .i(i), .sn(sn), .n(n), .done(done),
    .err(err4), .err_code(err_code4), .pass(pass4),
    .check_count(check_count4), .fail_cycle(fail_cycle4), .busy(busy4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic sel, input logic [9:0] ii,
                       input logic [9:0] ss, input logic d);
    @(negedge clk);
    in_valid = v; selector = sel; i = ii; sn = ss; done = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; done = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_err", err, 0);
    chk("rst_code", err_code, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", check_count, 0);
    chk("rst_fail", fail_cycle, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b1;

    // Done while idle is ignored
    drive(0, 0, 0, 0, 1);
    chk("idle_done_busy", busy, 0);
    chk("idle_done_pass", pass, 0);

    // Clean run, n=5
    n = 10'd5;
    drive(1, 1, 1, 0, 0);
    chk("clean_busy", busy, 1);
    drive(1, 1, 2, 1, 0);
    drive(1, 1, 3, 2, 0);
    drive(1, 1, 4, 3, 0);
    drive(1, 1, 5, 4, 0);
    drive(1, 0, 6, 5, 0);
    chk("clean_err_pre", err, 0);
    drive(0, 0, 0, 0, 1);
    chk("clean_pass", pass, 1);
    chk("clean_err", err, 0);
    chk("clean_cnt", check_count, 6);
    chk("clean_busy_done", busy, 0);
    drive(1, 1, 9, 9, 0);
    chk("done_frozen_cnt", check_count, 6);
    chk("done_frozen_err", err, 0);

    // Step violation outranks invariant
    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 0);
    drive(1, 1, 3, 3, 0);
    chk("step_err", err, 1);
    chk("step_code", err_code, 2);
    chk("step_fail", fail_cycle, 3);
    chk("step_busy", busy, 0);
    drive(1, 1, 7, 0, 1);
    chk("fail_frozen_code", err_code, 2);
    chk("fail_frozen_cnt", check_count, 3);

    // Bad init sample
    do_reset();
    drive(1, 1, 1, 5, 0);
    chk("init_code", err_code, 1);
    chk("init_fail", fail_cycle, 1);

    // Hold with prev_sel=0 is legal, then a missed step
    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(1, 0, 2, 1, 0);
    drive(1, 1, 2, 1, 0);
    chk("hold_err", err, 0);
    drive(1, 1, 2, 1, 0);
    chk("skip_code", err_code, 2);
    chk("skip_fail", fail_cycle, 4);

    // Post-condition failure, n=4
    do_reset();
    n = 10'd4;
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 0);
    drive(1, 1, 3, 2, 0);
    drive(1, 0, 4, 3, 0);
    drive(0, 0, 0, 0, 1);
    chk("post_code", err_code, 4);
    chk("post_pass", pass, 0);
    chk("post_fail", fail_cycle, 4);

    // Exit with sn=0 passes; done shares the cycle with a valid sample
    do_reset();
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 1, 0, 1);
    chk("zero_pass", pass, 1);
    chk("zero_err", err, 0);
    chk("zero_cnt", check_count, 2);

    // Same-cycle done with a bad step reports the step error
    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 5, 4, 1);
    chk("samecyc_code", err_code, 2);
    chk("samecyc_pass", pass, 0);

    // Wrap-around and counter saturation
    do_reset();
    for (int k = 1; k <= 1023; k++) begin
      logic [9:0] kk;
      kk = 10'(k);
      drive(1, 1, kk, kk - 10'd1, 0);
    end
    chk("wrap_pre_err", err, 0);
    drive(1, 1, 10'd0, 10'd1023, 0);
    chk("wrap_err", err, 0);
    chk("wrap_busy", busy, 1);
    chk("wrap_cnt", check_count, 1024);
    chk("sat_cnt4", check_count4, 15);
    chk("sat_err4", err4, 0);

    // Asynchronous reset mid-run
    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 0);
    drive(1, 1, 3, 2, 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_cnt", check_count, 0);
    chk("async_err", err, 0);
    @(negedge clk);
    rst = 1'b1;
    drive(1, 1, 1, 0, 0);
    chk("reinit_busy", busy, 1);
    chk("reinit_err", err, 0);
    chk("reinit_cnt", check_count, 1);

    do_reset();
    drive(1, 1, 1, 0, 0);
    drive(1, 1, 2, 1, 0);
    drive(1, 1, 3, 2, 0);
    do_reset();
    drive(1, 1, 4, 3, 0);
    chk("reinit_bad_code", err_code, 1);
    chk("reinit_bad_fail", fail_cycle, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
